// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for ram_bus_arbiter.
//   arb_state_t : arbiter FSM states
//   gnt_t       : which master currently owns the RAM port
//   state_grant : maps an FSM state to the owning master
package ram_arb_pkg;

    `include "tags.svh"

    typedef enum logic [1:0] {
        StIdle,
        StGntI,
        StGntD,
        StGntDLocked
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } gnt_t;

    function automatic gnt_t state_grant(input arb_state_t st);
        gnt_t g;
        case (st)
            StGntI:       g = GNT_I;
            StGntD:       g = GNT_D;
            StGntDLocked: g = GNT_D;
            default:      g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/tags.svh
// Wishbone address-tag encodings shared by the core and the RAM path.
// Tag layout is {mode[1:0], lock}. The lock bit marks the first (read) half
// of an atomic pair; the closing write carries the same mode with lock clear.
`ifndef TAGS_SVH
`define TAGS_SVH

localparam logic [1:0] TAG_MODE_PLAIN = 2'b00;
localparam logic [1:0] TAG_MODE_LRSC  = 2'b01;
localparam logic [1:0] TAG_MODE_AMO   = 2'b10;

localparam logic TAG_LOCK   = 1'b1;
localparam logic TAG_UNLOCK = 1'b0;

`endif

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: two-master Wishbone arbiter sharing the single ram_bus port
// between the instruction-fetch master (read-only) and the data master.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   i_cyc_i/i_stb_i/i_addr_i  fetch master request
//   i_ack_o/i_data_o          fetch master response
//   d_*_i                     data master request (sel, we, addr, addr tag, wdata)
//   d_ack_o/d_data_o          data master response
//   d_data_tag_o              SC failure flag returned from ram_bus
//   ram_*_o                   request forwarded to ram_bus
//   ram_ack_i/ram_data_i/ram_data_tag_i  response from ram_bus
//
// The grant is registered: a request seen in idle drives the RAM port on the
// following cycle. An AMO lock-read pins the grant to the data master until the
// matching unlock-write is acknowledged.
//
// Build option RAM_ARB_FAIRNESS_EN: after MAX_DATA_GRANTS consecutive data
// grants with a fetch waiting, the next contested arbitration goes to fetch.
module ram_bus_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_GRANTS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        i_cyc_i,
    input  logic        i_stb_i,
    input  logic [31:0] i_addr_i,
    output logic        i_ack_o,
    output logic [31:0] i_data_o,

    input  logic        d_cyc_i,
    input  logic        d_stb_i,
    input  logic [3:0]  d_sel_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [2:0]  d_addr_tag_i,
    input  logic [31:0] d_data_i,
    output logic        d_ack_o,
    output logic [31:0] d_data_o,
    output logic        d_data_tag_o,

    output logic        ram_cyc_o,
    output logic        ram_stb_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [2:0]  ram_addr_tag_o,
    output logic [31:0] ram_data_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_data_i,
    input  logic        ram_data_tag_i
);

    arb_state_t state, state_next;
    gnt_t       grant;

    logic d_req, i_req;
    logic lock_hit, unlock_hit;
    logic fetch_turn;

    assign d_req = d_cyc_i & d_stb_i;
    assign i_req = i_cyc_i & i_stb_i;

    // Only AMO tags hold the bus; LR/SC reservations are tracked by ram_bus itself.
    assign lock_hit   = ram_ack_i & ~d_we_i &
                        (d_addr_tag_i == {TAG_MODE_AMO, TAG_LOCK});
    assign unlock_hit = ram_ack_i &  d_we_i &
                        (d_addr_tag_i == {TAG_MODE_AMO, TAG_UNLOCK});

`ifdef RAM_ARB_FAIRNESS_EN
    logic [3:0] fair_cnt, fair_cnt_next;

    assign fetch_turn = (fair_cnt == MAX_DATA_GRANTS[3:0]);

    always_comb begin
        fair_cnt_next = fair_cnt;
        if (state == StIdle) begin
            if (state_next == StGntI) begin
                fair_cnt_next = 4'd0;
            end else if (state_next == StGntD && i_req && fair_cnt != 4'hf) begin
                fair_cnt_next = fair_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fair_cnt <= 4'd0;
        end else begin
            fair_cnt <= fair_cnt_next;
        end
    end
`else
    logic unused_max_data_grants;

    assign fetch_turn             = 1'b0;
    assign unused_max_data_grants = MAX_DATA_GRANTS[0];
`endif

    always_comb begin
        state_next = state;
        case (state)
            StIdle: begin
                if (d_req && !(i_req && fetch_turn)) begin
                    state_next = StGntD;
                end else if (i_req) begin
                    state_next = StGntI;
                end
            end
            StGntI: begin
                if (!i_cyc_i) state_next = StIdle;
            end
            StGntD: begin
                // Lock takes priority so a lock-read ack with cyc dropping still pins the bus.
                if (lock_hit) begin
                    state_next = StGntDLocked;
                end else if (!d_cyc_i) begin
                    state_next = StIdle;
                end
            end
            StGntDLocked: begin
                if (unlock_hit) state_next = StGntD;
            end
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Masking with rst_i keeps an ack arriving in the reset cycle from reaching a master.
    assign grant = rst_i ? GNT_NONE : state_grant(state);

    always_comb begin
        ram_cyc_o      = 1'b0;
        ram_stb_o      = 1'b0;
        ram_we_o       = 1'b0;
        ram_sel_o      = 4'b0000;
        ram_addr_o     = 32'd0;
        ram_addr_tag_o = 3'b000;
        ram_data_o     = 32'd0;
        i_ack_o        = 1'b0;
        i_data_o       = 32'd0;
        d_ack_o        = 1'b0;
        d_data_o       = 32'd0;
        d_data_tag_o   = 1'b0;
        case (grant)
            GNT_I: begin
                ram_cyc_o  = i_cyc_i;
                ram_stb_o  = i_stb_i;
                ram_sel_o  = 4'b1111;
                ram_addr_o = i_addr_i;
                i_ack_o    = ram_ack_i;
                i_data_o   = ram_data_i;
            end
            GNT_D: begin
                ram_cyc_o      = d_cyc_i;
                ram_stb_o      = d_stb_i;
                ram_we_o       = d_we_i;
                ram_sel_o      = d_sel_i;
                ram_addr_o     = d_addr_i;
                ram_addr_tag_o = d_addr_tag_i;
                ram_data_o     = d_data_i;
                d_ack_o        = ram_ack_i;
                d_data_o       = ram_data_i;
                d_data_tag_o   = ram_data_tag_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed testbench for ram_bus_arbiter. Inputs change 1 ns after the rising
// edge and outputs are sampled shortly after, away from the active edge.
module tb_ram_bus_arbiter;

`ifdef RAM_ARB_FAIRNESS_EN
    localparam int unsigned MaxGrants = 2;
`else
    localparam int unsigned MaxGrants = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cyc, i_stb, i_ack;
    logic [31:0] i_addr, i_data;
    logic        d_cyc, d_stb, d_we, d_ack, d_data_tag;
    logic [3:0]  d_sel;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_addr_tag;
    logic        ram_cyc, ram_stb, ram_we, ram_ack, ram_data_tag;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [2:0]  ram_addr_tag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_bus_arbiter #(
        .MAX_DATA_GRANTS(MaxGrants)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .i_cyc_i        (i_cyc),
        .i_stb_i        (i_stb),
        .i_addr_i       (i_addr),
        .i_ack_o        (i_ack),
        .i_data_o       (i_data),
        .d_cyc_i        (d_cyc),
        .d_stb_i        (d_stb),
        .d_sel_i        (d_sel),
        .d_we_i         (d_we),
        .d_addr_i       (d_addr),
        .d_addr_tag_i   (d_addr_tag),
        .d_data_i       (d_wdata),
        .d_ack_o        (d_ack),
        .d_data_o       (d_rdata),
        .d_data_tag_o   (d_data_tag),
        .ram_cyc_o      (ram_cyc),
        .ram_stb_o      (ram_stb),
        .ram_we_o       (ram_we),
        .ram_sel_o      (ram_sel),
        .ram_addr_o     (ram_addr),
        .ram_addr_tag_o (ram_addr_tag),
        .ram_data_o     (ram_wdata),
        .ram_ack_i      (ram_ack),
        .ram_data_i     (ram_rdata),
        .ram_data_tag_i (ram_data_tag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_req(input logic on);
        i_cyc  = on;
        i_stb  = on;
        i_addr = on ? 32'h0000_0300 : 32'd0;
    endtask

    task automatic data_req(input logic on, input logic [31:0] addr, input logic we,
                            input logic [2:0] tag, input logic [31:0] wdata);
        d_cyc      = on;
        d_stb      = on;
        d_sel      = on ? 4'b1111 : 4'b0000;
        d_we       = we;
        d_addr     = addr;
        d_addr_tag = tag;
        d_wdata    = wdata;
    endtask

    // Acks the current fetch grant, drops the fetch request, returns to idle.
    task automatic finish_fetch(input string tag);
        ram_ack = 1'b1;
        ram_rdata = 32'h0000_3333;
        #1;
        check({tag, "_i_ack"}, i_ack, 1);
        check({tag, "_d_ack"}, d_ack, 0);
        step();
        ram_ack = 1'b0;
        ram_rdata = 32'd0;
        fetch_req(1'b0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        fetch_req(1'b0);
        data_req(1'b0, 32'd0, 1'b0, 3'b000, 32'd0);
        ram_ack = 1'b0;
        ram_rdata = 32'd0;
        ram_data_tag = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_ram_cyc", ram_cyc, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_i_ack", i_ack, 0);
        check("rst_d_ack", d_ack, 0);

        // 1: fetch-only read
        fetch_req(1'b1);
        i_addr = 32'h0000_0100;
        #1;
        check("t1_idle_cyc", ram_cyc, 0);
        step();
        check("t1_cyc", ram_cyc, 1);
        check("t1_addr", ram_addr, 32'h0000_0100);
        check("t1_sel", ram_sel, 4'hf);
        check("t1_we", ram_we, 0);
        check("t1_tag", ram_addr_tag, 0);
        step();
        step();
        ram_ack = 1'b1;
        ram_rdata = 32'hDEAD_BEEF;
        #1;
        check("t1_i_ack", i_ack, 1);
        check("t1_i_data", i_data, 32'hDEAD_BEEF);
        check("t1_d_ack", d_ack, 0);
        check("t1_d_data", d_rdata, 0);
        step();
        ram_ack = 1'b0;
        ram_rdata = 32'd0;
        fetch_req(1'b0);
        #1;
        check("t1_release", ram_cyc, 0);
        step();

        // 2: simultaneous requests, data first
        fetch_req(1'b1);
        data_req(1'b1, 32'h0000_0200, 1'b0, 3'b000, 32'd0);
        #1;
        check("t2_idle_cyc", ram_cyc, 0);
        step();
        check("t2_first_addr", ram_addr, 32'h0000_0200);
        ram_ack = 1'b1;
        ram_rdata = 32'h1111_2222;
        #1;
        check("t2_d_ack", d_ack, 1);
        check("t2_d_data", d_rdata, 32'h1111_2222);
        check("t2_i_ack", i_ack, 0);
        check("t2_i_data", i_data, 0);
        step();
        ram_ack = 1'b0;
        ram_rdata = 32'd0;
        data_req(1'b0, 32'd0, 1'b0, 3'b000, 32'd0);
        step();
        check("t2_gap_cyc", ram_cyc, 0);
        check("t2_gap_addr", ram_addr, 0);
        step();
        check("t2_fetch_cyc", ram_cyc, 1);
        check("t2_fetch_addr", ram_addr, 32'h0000_0300);
        finish_fetch("t2");

        // 3: AMO lock/unlock with fetch pending throughout
        fetch_req(1'b1);
        data_req(1'b1, 32'h0000_0100, 1'b0, 3'b101, 32'd0); // {AMO, LOCK}
        step();
        check("t3_lock_tag", ram_addr_tag, 3'b101);
        ram_ack = 1'b1;
        ram_rdata = 32'h0000_0055;
        #1;
        check("t3_lock_ack", d_ack, 1);
        step();
        ram_ack = 1'b0;
        ram_rdata = 32'd0;
        d_cyc = 1'b0;
        d_stb = 1'b0;
        #1;
        check("t3_gap0_addr", ram_addr, 32'h0000_0100);
        check("t3_gap0_i_ack", i_ack, 0);
        step();
        check("t3_gap1_addr", ram_addr, 32'h0000_0100);
        check("t3_gap1_cyc", ram_cyc, 0);
        step();
        data_req(1'b1, 32'h0000_0100, 1'b1, 3'b100, 32'h0000_0077); // {AMO, UNLOCK}
        #1;
        check("t3_unlock_cyc", ram_cyc, 1);
        check("t3_unlock_we", ram_we, 1);
        check("t3_unlock_data", ram_wdata, 32'h0000_0077);
        step();
        ram_ack = 1'b1;
        #1;
        check("t3_unlock_ack", d_ack, 1);
        check("t3_unlock_i_ack", i_ack, 0);
        step();
        ram_ack = 1'b0;
        data_req(1'b0, 32'd0, 1'b0, 3'b000, 32'd0);
        step();
        check("t3_idle_cyc", ram_cyc, 0);
        step();
        check("t3_fetch_addr", ram_addr, 32'h0000_0300);
        finish_fetch("t3");

        // 4a: LR read tagged {LRSC, LOCK} must not hold the grant
        fetch_req(1'b1);
        data_req(1'b1, 32'h0000_0180, 1'b0, 3'b011, 32'd0);
        step();
        check("t4_lr_tag", ram_addr_tag, 3'b011);
        ram_ack = 1'b1;
        #1;
        check("t4_lr_ack", d_ack, 1);
        step();
        ram_ack = 1'b0;
        data_req(1'b0, 32'd0, 1'b0, 3'b000, 32'd0);
        step();
        check("t4_lr_no_hold", ram_cyc, 0);
        step();
        check("t4_fetch_addr", ram_addr, 32'h0000_0300);
        finish_fetch("t4");

        // 4b: failing SC write returns the data tag
        data_req(1'b1, 32'h0000_0180, 1'b1, 3'b010, 32'h0000_0099);
        step();
        check("t4_sc_we", ram_we, 1);
        ram_ack = 1'b1;
        ram_data_tag = 1'b1;
        #1;
        check("t4_sc_ack", d_ack, 1);
        check("t4_sc_tag", d_data_tag, 1);
        check("t4_sc_i_ack", i_ack, 0);
        step();
        ram_ack = 1'b0;
        ram_data_tag = 1'b0;
        data_req(1'b0, 32'd0, 1'b0, 3'b000, 32'd0);
        step();
        check("t4_sc_idle", ram_cyc, 0);

        // 5: both masters requesting continuously
        fetch_req(1'b1);
        data_req(1'b1, 32'h0000_0200, 1'b0, 3'b000, 32'd0);
        for (int k = 0; k < 6; k++) begin
            logic exp_d;
`ifdef RAM_ARB_FAIRNESS_EN
            exp_d = (k % 3) != 2;
`else
            exp_d = 1'b1;
`endif
            step();
            check($sformatf("t5_grant%0d", k), ram_addr,
                  exp_d ? 32'h0000_0200 : 32'h0000_0300);
            ram_ack = 1'b1;
            #1;
            step();
            ram_ack = 1'b0;
            if (exp_d) data_req(1'b0, 32'd0, 1'b0, 3'b000, 32'd0);
            else fetch_req(1'b0);
            step();
            fetch_req(1'b1);
            data_req(1'b1, 32'h0000_0200, 1'b0, 3'b000, 32'd0);
        end
        fetch_req(1'b0);
        data_req(1'b0, 32'd0, 1'b0, 3'b000, 32'd0);
        step();

        // 6: reset in GNT_D with an ack pending
        data_req(1'b1, 32'h0000_0200, 1'b0, 3'b000, 32'd0);
        step();
        check("t6_granted", ram_cyc, 1);
        ram_ack = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_rst_d_ack", d_ack, 0);
        step();
        check("t6_cyc", ram_cyc, 0);
        check("t6_addr", ram_addr, 0);
        check("t6_d_ack", d_ack, 0);
        check("t6_i_ack", i_ack, 0);
        rst = 1'b0;
        ram_ack = 1'b0;
        #1;
        check("t6_idle_cyc", ram_cyc, 0);
        step();
        check("t6_regrant", ram_cyc, 1);
        data_req(1'b0, 32'd0, 1'b0, 3'b000, 32'd0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
